gpio_bank: RTL and testbench
============================

// Module: gpio_bank
// PURPOSE
//  Parametrised memory-mapped GPIO bank; successor to the fixed 8-bit GPIO.
//  - Per-pin direction; atomic set/clear/toggle writes.
//  - Synchronised inputs, with rising/falling edge capture into a W1C status register and a level IRQ.
//  - Sits on the data-memory bus beside RAM. The top-level decoder asserts gpio_wren only inside the GPIO window.
// PARAMETERS
//  WIDTH        8   pin count, 1..32; register bits [31:WIDTH] read 0, writes ignored
//  SYNC_STAGES  2   input synchroniser depth, >=2
//  RST_OUT      '0  reset value of DATA_OUT, WIDTH bits
//  DEBOUNCE_CNT 16  stable cycles required per pin; used only with GPIO_DEBOUNCE_EN
// PORTS
//  clk           in   1      system clock, single clock domain
//  rst           in   1      asynchronous, active-high reset
//  gpio_addr     in   32     RV32I_OPERAND_t byte address; only [5:2] decoded (word offset)
//  gpio_wrdata   in   32     RV32I_OPERAND_t write data
//  gpio_wren     in   1      write strobe, one cycle per write
//  gpio_port_in  in   WIDTH  asynchronous pin inputs
//  gpio_port_out out  WIDTH  output data register
//  gpio_port_oe  out  WIDTH  output enable, 1 = pin driven
//  gpio_rddata   out  32     RV32I_OPERAND_t combinational read data
//  gpio_irq      out  1      |(IRQ_STATUS), level
// BEHAVIOUR
//  Register map (offset: name, access):
//   0x00 DATA_IN RO      0x04 DATA_OUT RW    0x08 DIR RW
//   0x0C OUT_SET W1S     0x10 OUT_CLR W1C    0x14 OUT_TGL W1T
//   0x18 RISE_EN RW      0x1C FALL_EN RW     0x20 IRQ_STATUS RW1C
//   Other offsets read 0; writes to them are ignored.
//   Write-only offsets read 0.
//  Reset values: DATA_OUT=RST_OUT; all other registers 0; gpio_port_oe=0; gpio_irq=0; synchroniser flops 0.
//  Writes take effect on the clk edge where gpio_wren=1.
//  Reads are combinational from current register state. Same-cycle read of a register being written returns the old value.
//  Input path: gpio_port_in -> SYNC_STAGES flops -> sync_in. DATA_IN=sync_in.
//   A pin change is visible in DATA_IN SYNC_STAGES cycles after the edge it is sampled on.
//  Edge detect: prev <= sync_in each cycle.
//   rise = sync_in & ~prev & RISE_EN; fall = ~sync_in & prev & FALL_EN.
//   IRQ_STATUS[i] sets on the cycle after the edge appears in sync_in.
//   Edge detection is active regardless of DIR, so an output pin looped back still interrupts.
//  IRQ_STATUS update: status_n = (status & ~(wren_at_0x20 ? wrdata : 0)) | rise | fall.
//   If set and clear hit the same bit in the same cycle, set wins.
//  gpio_irq is combinational from the registered status and needs no separate enable; masking is done by RISE_EN/FALL_EN.
//  Disabling RISE_EN/FALL_EN leaves already-latched status bits set.
//  OUT_SET/OUT_CLR/OUT_TGL apply to DATA_OUT only; a zero bit leaves that pin unchanged. OUT_TGL of 0xFF flips all 8 pins.
//  Reset asserted mid-operation clears state immediately, asynchronously. Edges in flight are lost.
//   After reset is released, prev=0, so an input that is already high produces one rising edge if RISE_EN is set.
// CONFIGURATION
//  GPIO_DEBOUNCE_EN defined:
//   - Per-pin counter inserted after the synchroniser.
//   - Debounced value updates only after sync_in differs from it for DEBOUNCE_CNT consecutive cycles.
//   - The counter restarts whenever sync_in returns to the debounced value.
//   - DATA_IN and edge detect use the debounced value. Added latency is DEBOUNCE_CNT cycles.
//  GPIO_DEBOUNCE_EN undefined: no counters; DEBOUNCE_CNT is unused; the behaviour above is exact.
// STRUCTURE
//  mem_pkg: GPIO_BASE_ADDR and offset constants GPIO_DATA_IN_OFS..GPIO_IRQ_STATUS_OFS (4-bit word index).
//  fe_pkg: RV32I_OPERAND_t, already existing.
//  Flops use FF_D_RST / FF_D_RST_EN from RV32I_defines.sv.
//  Sub-module gpio_in_cond (WIDTH, SYNC_STAGES, DEBOUNCE_CNT): synchroniser plus optional debounce; outputs the conditioned pin vector.
//  Decode, registers and edge logic live in gpio_bank.
// TESTING
//  1 Reset, read all offsets -> DATA_OUT=RST_OUT, others 0; port_oe=0; irq=0.
//  2 Write DATA_OUT=0xA5, OUT_SET=0x0F, OUT_CLR=0x80, OUT_TGL=0x03 -> port_out=0x2C; read 0x04=0x0000002C.
//  3 DIR=0xF0 -> port_oe=0xF0; write 0xFFFFFFFF to DATA_OUT with WIDTH=8 -> reads 0x000000FF.
//  4 port_in 0x00->0x01 -> DATA_IN=0x01 exactly SYNC_STAGES cycles later.
//    With RISE_EN=0x01, status=0x01 and irq=1 one cycle after that.
//    With RISE_EN=0, status stays 0.
//  5 FALL_EN=0x02, pin1 falls in the same cycle IRQ_STATUS is written with 0x02 -> bit1 stays 1 (set wins).
//    A later W1C of 0x02 -> irq=0.
//  6 GPIO_DEBOUNCE_EN, DEBOUNCE_CNT=4, glitch pin0 high for 3 cycles -> DATA_IN stays 0, no status.
//    Hold high for 4 cycles -> DATA_IN=1.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: operand type, register word offsets and small helpers shared
// by the GPIO bank and its input conditioner.
package gpio_bank_pkg;

    // 32-bit bus operand used for addresses and data on the data-memory bus.
    typedef logic [31:0] rv32i_operand_t;

    // Base of the GPIO window; the system decoder qualifies gpio_wren with it.
    localparam rv32i_operand_t GPIO_BASE_ADDR = 32'h1000_0000;

    // Word index (byte address bits [5:2]) of each register.
    typedef enum logic [3:0] {
        GPIO_DATA_IN_OFS    = 4'h0,
        GPIO_DATA_OUT_OFS   = 4'h1,
        GPIO_DIR_OFS        = 4'h2,
        GPIO_OUT_SET_OFS    = 4'h3,
        GPIO_OUT_CLR_OFS    = 4'h4,
        GPIO_OUT_TGL_OFS    = 4'h5,
        GPIO_RISE_EN_OFS    = 4'h6,
        GPIO_FALL_EN_OFS    = 4'h7,
        GPIO_IRQ_STATUS_OFS = 4'h8
    } gpio_ofs_e;

    // Word index of a byte address inside the GPIO window.
    function automatic logic [3:0] word_ofs(input rv32i_operand_t addr);
        return addr[5:2];
    endfunction

    // Bits needed for a counter that runs 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: synchroniser chain for the asynchronous GPIO pins, followed by
// an optional per-pin debounce stage built only when GPIO_DEBOUNCE_EN is
// defined. Without it the output is the synchronised pin vector.
module gpio_in_cond
    import gpio_bank_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] cond_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_in;

    // Shift raw pins through SYNC_STAGES flops; the oldest stage is the synchronised value.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values, whatever the statement order.
        // NOTE: synchroniser flops are reset too, so DATA_IN and the edge history start from a known 0.
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pins_i};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = cnt_width(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [WIDTH-1:0]            deb_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;

    // Per pin: adopt sync_in once it has differed from the debounced value for DEBOUNCE_CNT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_in[i] != deb_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        deb_q[i] <= sync_in[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign cond_o = deb_q;
`else
    // DEBOUNCE_CNT only sizes the debounce stage; a non-positive value is never legal.
    if (DEBOUNCE_CNT < 1) begin : g_deb_cnt_unused
    end

    assign cond_o = sync_in;
`endif

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: parametrised memory-mapped GPIO bank with per-pin direction,
// atomic set/clear/toggle of DATA_OUT, synchronised inputs and rising/falling
// edge capture into a W1C IRQ_STATUS register driving a level interrupt.
// Optional input debounce is built when GPIO_DEBOUNCE_EN is defined.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               SYNC_STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_OUT      = '0,
    parameter int               DEBOUNCE_CNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  rv32i_operand_t   gpio_addr,
    input  rv32i_operand_t   gpio_wrdata,
    input  logic             gpio_wren,
    input  logic [WIDTH-1:0] gpio_port_in,
    output logic [WIDTH-1:0] gpio_port_out,
    output logic [WIDTH-1:0] gpio_port_oe,
    output rv32i_operand_t   gpio_rddata,
    output logic             gpio_irq
);

    logic [3:0]       ofs;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] pin_in;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] prev_q;

    logic [WIDTH-1:0] status_clr;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rd_word;

    // Address bits outside [5:2] and data bits above WIDTH are ignored by design.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{gpio_addr[31:6], gpio_addr[1:0], gpio_wrdata};

    assign ofs   = word_ofs(gpio_addr);
    assign wdata = gpio_wrdata[WIDTH-1:0];

    gpio_in_cond #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_in_cond (
        .clk    (clk),
        .rst    (rst),
        .pins_i (gpio_port_in),
        .cond_o (pin_in)
    );

    // Edges are seen whatever DIR says, so looped-back outputs still interrupt.
    assign rise = pin_in & ~prev_q & rise_en_q;
    assign fall = ~pin_in & prev_q & fall_en_q;

    // Decode a bus write into register next-state; edge sets win over W1C clears.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves one unassigned and infers a latch.
        data_out_d = data_out_q;
        dir_d      = dir_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        status_clr = '0;
        if (gpio_wren) begin
            case (ofs)
                GPIO_DATA_OUT_OFS:   data_out_d = wdata;
                GPIO_DIR_OFS:        dir_d      = wdata;
                GPIO_OUT_SET_OFS:    data_out_d = data_out_q | wdata;
                GPIO_OUT_CLR_OFS:    data_out_d = data_out_q & ~wdata;
                GPIO_OUT_TGL_OFS:    data_out_d = data_out_q ^ wdata;
                GPIO_RISE_EN_OFS:    rise_en_d  = wdata;
                GPIO_FALL_EN_OFS:    fall_en_d  = wdata;
                GPIO_IRQ_STATUS_OFS: status_clr = wdata;
                default:             ;
            endcase
        end
        status_d = (status_q & ~status_clr) | rise | fall;
    end

    // Register state and the one-cycle edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= RST_OUT;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            prev_q     <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            prev_q     <= pin_in;
        end
    end

    // Combinational read-back of current register state; write-only and unmapped offsets read 0.
    always_comb begin
        rd_word = '0;
        case (ofs)
            GPIO_DATA_IN_OFS:    rd_word = pin_in;
            GPIO_DATA_OUT_OFS:   rd_word = data_out_q;
            GPIO_DIR_OFS:        rd_word = dir_q;
            GPIO_RISE_EN_OFS:    rd_word = rise_en_q;
            GPIO_FALL_EN_OFS:    rd_word = fall_en_q;
            GPIO_IRQ_STATUS_OFS: rd_word = status_q;
            default:             rd_word = '0;
        endcase
    end

    assign gpio_rddata   = 32'(rd_word);
    assign gpio_port_out = data_out_q;
    assign gpio_port_oe  = dir_q;
    assign gpio_irq      = |status_q;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed and randomized bench for gpio_bank (WIDTH=8,
// SYNC_STAGES=2, RST_OUT=0x3C). A behavioural register model predicts every
// output; the GPIO_DEBOUNCE_EN build adds the glitch/hold checks.
module tb_gpio_bank;

    localparam int         WIDTH   = 8;
    localparam int         SS      = 2;
    localparam logic [7:0] RST_OUT = 8'h3C;
    localparam int         DEB     = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int         LAT     = SS + DEB;
`else
    localparam int         LAT     = SS;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      gpio_addr;
    logic [31:0]      gpio_wrdata;
    logic             gpio_wren;
    logic [WIDTH-1:0] gpio_port_in;
    logic [WIDTH-1:0] gpio_port_out;
    logic [WIDTH-1:0] gpio_port_oe;
    logic [31:0]      gpio_rddata;
    logic             gpio_irq;

    int total = 0;
    int bad   = 0;

    // Reference model state: what software would see in each register.
    logic [7:0] m_out, m_dir, m_rise, m_fall, m_status, m_prev, m_in;
    logic [7:0] pin_hist[$];
    logic [7:0] pins_v;

    gpio_bank #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SS),
        .RST_OUT      (RST_OUT),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gpio_addr    (gpio_addr),
        .gpio_wrdata  (gpio_wrdata),
        .gpio_wren    (gpio_wren),
        .gpio_port_in (gpio_port_in),
        .gpio_port_out(gpio_port_out),
        .gpio_port_oe (gpio_port_oe),
        .gpio_rddata  (gpio_rddata),
        .gpio_irq     (gpio_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = RST_OUT; m_dir = 0; m_rise = 0; m_fall = 0; m_status = 0; m_prev = 0; m_in = 0;
        pin_hist = {};
        for (int i = 0; i < LAT; i++) pin_hist.push_back(8'h00);
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] ofs);
        case (ofs)
            4'h0:    return {24'h0, m_in};
            4'h1:    return {24'h0, m_out};
            4'h2:    return {24'h0, m_dir};
            4'h6:    return {24'h0, m_rise};
            4'h7:    return {24'h0, m_fall};
            4'h8:    return {24'h0, m_status};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the programmer's-view model.
    task automatic model_edge(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [7:0] pins);
        logic [7:0] r, f, clr, w;
        w   = d[7:0];
        clr = 8'h00;
        r   = m_in & ~m_prev & m_rise;
        f   = ~m_in & m_prev & m_fall;
        if (wr) begin
            case (a[5:2])
                4'h1: m_out  = w;
                4'h2: m_dir  = w;
                4'h3: m_out  = m_out | w;
                4'h4: m_out  = m_out & ~w;
                4'h5: m_out  = m_out ^ w;
                4'h6: m_rise = w;
                4'h7: m_fall = w;
                4'h8: clr    = w;
                default: ;
            endcase
        end
        m_status = (m_status & ~clr) | r | f;
        m_prev   = m_in;
        pin_hist.push_back(pins);
        void'(pin_hist.pop_front());
        m_in = pin_hist[0];
    endtask

    // Starts just after a negedge, ends at the next negedge; rddata then shows offset ra.
    task automatic do_cycle(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [31:0] ra);
        gpio_wren    = wr;
        gpio_addr    = a;
        gpio_wrdata  = d;
        gpio_port_in = pins_v;
        #1;
        check("rd_old_value", gpio_rddata, model_read(a[5:2]));
        @(posedge clk);
        model_edge(wr, a, d, pins_v);
        #1;
        gpio_wren = 1'b0;
        gpio_addr = ra;
        #1;
        check("port_out", {24'h0, gpio_port_out}, {24'h0, m_out});
        check("port_oe", {24'h0, gpio_port_oe}, {24'h0, m_dir});
        check("irq", {31'h0, gpio_irq}, {31'h0, |m_status});
        check("rd_model", gpio_rddata, model_read(ra[5:2]));
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        do_cycle(1'b1, a, d, a);
    endtask

    task automatic idle(input logic [31:0] ra);
        do_cycle(1'b0, ra, 32'h0, ra);
    endtask

    initial begin
        rst = 1'b1; gpio_wren = 0; gpio_addr = 0; gpio_wrdata = 0; gpio_port_in = 0; pins_v = 0;
        model_reset();

        // 1: reset state of every offset and output.
        @(negedge clk);
        check("rst_port_out", {24'h0, gpio_port_out}, {24'h0, RST_OUT});
        check("rst_port_oe", {24'h0, gpio_port_oe}, 32'h0);
        check("rst_irq", {31'h0, gpio_irq}, 32'h0);
        for (int o = 0; o < 16; o++) begin
            gpio_addr = 32'(o) << 2;
            #1;
            check($sformatf("rst_rd_%0h", o), gpio_rddata, (o == 1) ? {24'h0, RST_OUT} : 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // 2: DATA_OUT write then set/clear/toggle.
        wr(32'h04, 32'hA5);
        wr(32'h0C, 32'h0F);
        wr(32'h10, 32'h80);
        wr(32'h14, 32'h03);
        check("t2_port_out", {24'h0, gpio_port_out}, 32'h2C);
        idle(32'h04);
        check("t2_rd_out", gpio_rddata, 32'h0000_002C);

        // 3: direction and truncation of wide writes.
        wr(32'h08, 32'hF0);
        check("t3_oe", {24'h0, gpio_port_oe}, 32'hF0);
        wr(32'h04, 32'hFFFF_FFFF);
        idle(32'h04);
        check("t3_rd_out", gpio_rddata, 32'h0000_00FF);
        wr(32'h14, 32'hFF);
        check("t3_tgl_all", {24'h0, gpio_port_out}, 32'h00);

        // 4: input latency and rising-edge capture.
        pins_v = 8'h01;
        repeat (LAT - 1) idle(32'h00);
        check("t4_in_early", gpio_rddata, 32'h0);
        idle(32'h00);
        check("t4_in_seen", gpio_rddata, 32'h1);
        idle(32'h20);
        check("t4_no_rise_en", gpio_rddata, 32'h0);
        pins_v = 8'h00;
        repeat (LAT + 2) idle(32'h00);
        wr(32'h18, 32'h01);
        pins_v = 8'h01;
        repeat (LAT) idle(32'h00);
        check("t4_in_seen2", gpio_rddata, 32'h1);
        check("t4_irq_not_yet", {31'h0, gpio_irq}, 32'h0);
        idle(32'h20);
        check("t4_status", gpio_rddata, 32'h1);
        check("t4_irq", {31'h0, gpio_irq}, 32'h1);

        // 5: falling edge and W1C in the same cycle; set wins.
        wr(32'h20, 32'hFF);
        wr(32'h1C, 32'h02);
        pins_v = 8'h03;
        repeat (LAT + 1) idle(32'h20);
        check("t5_no_status", gpio_rddata, 32'h0);
        pins_v = 8'h01;
        repeat (LAT) idle(32'h20);
        wr(32'h20, 32'h02);
        idle(32'h20);
        check("t5_set_wins", gpio_rddata, 32'h2);
        check("t5_irq_held", {31'h0, gpio_irq}, 32'h1);
        wr(32'h20, 32'h02);
        check("t5_irq_clear", {31'h0, gpio_irq}, 32'h0);

        // Disabling the enable keeps a latched bit.
        wr(32'h18, 32'h04);
        pins_v = 8'h05;
        repeat (LAT + 1) idle(32'h20);
        wr(32'h18, 32'h00);
        idle(32'h20);
        check("latched_kept", gpio_rddata, 32'h4);

        // Asynchronous reset mid-cycle.
        #2 rst = 1'b1;
        #1;
        check("arst_port_out", {24'h0, gpio_port_out}, {24'h0, RST_OUT});
        check("arst_oe", {24'h0, gpio_port_oe}, 32'h0);
        check("arst_irq", {31'h0, gpio_irq}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 2) idle(32'h00);

`ifndef GPIO_DEBOUNCE_EN
        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, d, ra;
            if ($urandom_range(0, 3) == 0) pins_v = 8'($urandom);
            a  = $urandom;
            d  = $urandom;
            ra = $urandom;
            a[5:2]  = 4'($urandom_range(0, 9));
            ra[5:2] = 4'($urandom_range(0, 15));
            do_cycle($urandom_range(0, 2) != 0, a, d, ra);
        end
`else
        // 6: debounce rejects a 3-cycle glitch and accepts a 4-cycle hold.
        pins_v = 8'h00;
        wr(32'h18, 32'h01);
        repeat (LAT + 2) idle(32'h00);
        wr(32'h20, 32'hFF);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            gpio_addr    = 32'h00;
            gpio_port_in = (c < 3) ? 8'h01 : 8'h00;
            @(posedge clk);
            #1;
            check("t6_glitch_in", gpio_rddata, 32'h0);
            check("t6_glitch_irq", {31'h0, gpio_irq}, 32'h0);
        end
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            gpio_port_in = 8'h01;
            @(posedge clk);
            #1;
            check("t6_hold_in", gpio_rddata, (c == LAT) ? 32'h1 : 32'h0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
